// File: rtl/shift_add_multiplier_if.sv
// Bundle between the shift-add multiplier, its control unit and the external
// EIGHT_BIT_ADDER. The multiplier sits on the slave side; the control unit
// and adder together form the master side.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 8
);
    // control-unit handshake
    logic                 START;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 BUSY;
    logic                 DONE;
    logic [2*WIDTH-1:0]   PRODUCT;
    // external adder connection
    logic [WIDTH-1:0]     ADD_A;
    logic [WIDTH-1:0]     ADD_B;
    logic                 ADD_CIN;
    logic [WIDTH-1:0]     ADD_SUM;
    logic                 ADD_COUT;

    modport slave (
        input  START, A, B, ADD_SUM, ADD_COUT,
        output BUSY, DONE, PRODUCT, ADD_A, ADD_B, ADD_CIN
    );

    modport master (
        output START, A, B, ADD_SUM, ADD_COUT,
        input  BUSY, DONE, PRODUCT, ADD_A, ADD_B, ADD_CIN
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier, one shift-and-add iteration per
// clock. The addition itself is done by an external adder that this block
// drives from its registers and whose sum/carry it consumes in the same cycle.
module shift_add_multiplier #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    shift_add_multiplier_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     m_reg;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     q;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   product;

    logic                 load;
    logic                 step;
    logic                 last;
    logic [WIDTH:0]       add_term;
    logic [2*WIDTH-1:0]   shifted;

    // Adder inputs come straight from registers so there is no path from the
    // adder's sum back to any output of this block.
    assign bus.ADD_A   = acc;
    assign bus.ADD_B   = q[0] ? m_reg : '0;
    assign bus.ADD_CIN = 1'b0;

    assign bus.BUSY    = (state == RUN);
    assign bus.DONE    = (state == FIN);
    assign bus.PRODUCT = product;

    // Carry-out is kept as the top bit so the largest product stays exact.
    assign add_term = q[0] ? {bus.ADD_COUT, bus.ADD_SUM} : {1'b0, acc};
    assign shifted  = {add_term, q[WIDTH-1:1]};
    assign last     = (cnt == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and datapath control; FIN accepts START like IDLE so
    // back-to-back products have no idle gap.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.START) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_nxt = FIN;
            end
            FIN: begin
                if (bus.START) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration shift and result latch.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_reg   <= '0;
            acc     <= '0;
            q       <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (load) begin
            m_reg <= bus.A;
            q     <= bus.B;
            acc   <= '0;
            cnt   <= '0;
        end else if (step) begin
            {acc, q} <= shifted;
            cnt      <= cnt + 1'b1;
            if (last) product <= shifted;
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier with a behavioural adder attached.
module tb_shift_add_multiplier;
    localparam int W = 8;

    logic CLK = 1'b0;
    logic RESET_N;
    always #5 CLK = ~CLK;

    shift_add_multiplier_if #(.WIDTH(W)) bus ();

    // external adder
    assign {bus.ADD_COUT, bus.ADD_SUM} = {1'b0, bus.ADD_A} + {1'b0, bus.ADD_B} + {8'd0, bus.ADD_CIN};

    shift_add_multiplier #(.WIDTH(W), .CNT_W(4)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        bit          need_cout;
    } vec_t;

    vec_t        vecs[7];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] prev_p   = 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One full multiply: START for one cycle, then watch BUSY/DONE/adder ports.
    task automatic run_vec(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                           input bit need_cout);
        int   done_at = 0;
        int   busy_n  = 0;
        bit   saw_cout = 0;
        logic [7:0] exp_b;
        @(negedge CLK);
        bus.A = a; bus.B = b; bus.START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.START = 1'b0;
        bus.A = ~a; bus.B = ~b;      // must not affect the run
        chk("product_stable_in_run", bus.PRODUCT, prev_p);
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) begin @(posedge CLK); @(negedge CLK); end
            if (bus.DONE) begin done_at = k; break; end
            if (bus.BUSY) begin
                busy_n++;
                if (k <= 8) begin
                    exp_b = b[k-1] ? a : 8'h00;
                    chk("add_b", bus.ADD_B, exp_b);
                end
                chk("add_cin", bus.ADD_CIN, 0);
                if (bus.ADD_COUT) saw_cout = 1;
            end
        end
        chk("done_edge", done_at, 9);
        chk("busy_cycles", busy_n, 8);
        chk("product", bus.PRODUCT, p);
        chk("busy_in_fin", bus.BUSY, 0);
        if (need_cout) chk("cout_seen", saw_cout, 1);
        @(posedge CLK); @(negedge CLK);
        chk("done_one_pulse", bus.DONE, 0);
        repeat (2) begin @(posedge CLK); @(negedge CLK); end
        chk("product_held", bus.PRODUCT, p);
        prev_p = p;
    endtask

    initial begin
        bit saw_done;
        vecs[0] = '{8'd13,  8'd11,  16'h008F, 1'b0};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01, 1'b1};
        vecs[2] = '{8'd0,   8'd200, 16'h0000, 1'b0};
        vecs[3] = '{8'd200, 8'd0,   16'h0000, 1'b0};
        vecs[4] = '{8'd1,   8'd200, 16'h00C8, 1'b0};
        vecs[5] = '{8'd7,   8'd6,   16'h002A, 1'b0};
        vecs[6] = '{8'd170, 8'd85,  16'h3872, 1'b0};

        RESET_N = 1'b0; bus.START = 1'b0; bus.A = '0; bus.B = '0;
        #12;
        chk("rst_busy",    bus.BUSY,    0);
        chk("rst_done",    bus.DONE,    0);
        chk("rst_product", bus.PRODUCT, 0);
        chk("rst_add_a",   bus.ADD_A,   0);
        chk("rst_add_b",   bus.ADD_B,   0);
        chk("rst_add_cin", bus.ADD_CIN, 0);
        @(negedge CLK);
        RESET_N = 1'b1;

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].need_cout);

        // Mid-run START ignored; START held through FIN is accepted back-to-back.
        @(negedge CLK);
        bus.A = 8'd7; bus.B = 8'd6; bus.START = 1'b1;
        @(posedge CLK);
        for (int k = 1; k <= 19; k++) begin
            @(negedge CLK);
            case (k)
                1:  bus.START = 1'b0;
                3:  begin bus.START = 1'b1; bus.A = 8'd3; bus.B = 8'd3; end
                4:  begin bus.START = 1'b0; chk("b2b_busy_mid", bus.BUSY, 1); end
                8:  begin bus.START = 1'b1; chk("b2b_no_early_done", bus.DONE, 0); end
                9:  begin
                        chk("b2b_done1", bus.DONE, 1);
                        chk("b2b_prod1", bus.PRODUCT, 16'h002A);
                        chk("b2b_fin_busy", bus.BUSY, 0);
                    end
                10: begin
                        bus.START = 1'b0;
                        chk("b2b_no_gap_busy", bus.BUSY, 1);
                        chk("b2b_done_low", bus.DONE, 0);
                    end
                17: begin
                        chk("b2b_done_not_yet", bus.DONE, 0);
                        chk("b2b_prod_held", bus.PRODUCT, 16'h002A);
                    end
                18: begin
                        chk("b2b_done2", bus.DONE, 1);
                        chk("b2b_prod2", bus.PRODUCT, 16'h0009);
                    end
                19: begin
                        chk("b2b_done2_pulse", bus.DONE, 0);
                        chk("b2b_idle_busy", bus.BUSY, 0);
                    end
                default: ;
            endcase
            if (k < 19) @(posedge CLK);
        end

        // Asynchronous reset in the middle of a run.
        @(negedge CLK);
        bus.A = 8'd100; bus.B = 8'd100; bus.START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.START = 1'b0;
        repeat (3) begin @(posedge CLK); @(negedge CLK); end
        @(posedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        chk("arst_busy",    bus.BUSY,    0);
        chk("arst_done",    bus.DONE,    0);
        chk("arst_product", bus.PRODUCT, 0);
        chk("arst_add_a",   bus.ADD_A,   0);
        chk("arst_add_b",   bus.ADD_B,   0);
        @(negedge CLK);
        RESET_N = 1'b1;
        saw_done = 0;
        repeat (15) begin
            @(posedge CLK); @(negedge CLK);
            if (bus.DONE) saw_done = 1;
        end
        chk("arst_no_done", saw_done, 0);
        prev_p = 16'h0;
        run_vec(8'd100, 8'd100, 16'h2710, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential 8x8 unsigned multiplier; shift-and-add over 8 iterations; 16-bit product.
- Direct neighbour of EIGHT_BIT_ADDER: drives the adder's A/B/CIN and consumes its SUM/COUT in the same cycle. The adder is instantiated externally; no adder logic inside this block.
- Start/busy/done handshake to the control unit.

Parameters:
- WIDTH, 8, operand width; must equal the connected adder width; product is 2*WIDTH.
- CNT_W, 4, iteration counter width; must hold values 0..WIDTH.

Ports:
- CLK  input  1  rising-edge clock
- RESET_N  input  1  asynchronous active-low reset
- START  input  1  request; sampled on rising CLK only while BUSY=0
- A  input  WIDTH  multiplicand; captured when START is accepted
- B  input  WIDTH  multiplier; captured when START is accepted
- BUSY  output  1  high during load-to-last-iteration
- DONE  output  1  one-cycle pulse; PRODUCT is valid
- PRODUCT  output  2*WIDTH  registered result; held until the next completion
- ADD_A  output  WIDTH  to adder A; equals ACC register
- ADD_B  output  WIDTH  to adder B; equals M when Q[0]=1, else 0
- ADD_CIN  output  1  to adder CIN; constant 0
- ADD_SUM  input  WIDTH  from adder SUM
- ADD_COUT  input  1  from adder COUT

Behaviour:
- Registers: M (multiplicand), ACC (high half), Q (low half / multiplier), CNT, PRODUCT, and state.
- Reset (asynchronous, RESET_N=0):
  - state=IDLE; M, ACC, Q, CNT, PRODUCT = 0; BUSY=0; DONE=0.
  - ADD_A=0 and ADD_B=0 immediately.
  - Reset overrides everything, including mid-run; partial results are discarded and no DONE is produced.
- States: IDLE, RUN, FIN.
- IDLE:
  - START=1 at an edge: M<=A, Q<=B, ACC<=0, CNT<=0, go to RUN.
  - Otherwise hold.
- RUN, one iteration per edge:
  - Adder term: {C,S} = {ADD_COUT,ADD_SUM} if Q[0]=1, else {0,ACC}.
  - Shift: {ACC,Q} <= {C,S,Q[WIDTH-1:1]}.
  - Counter: CNT<=CNT+1.
  - When the iteration with CNT=WIDTH-1 completes: PRODUCT <= new {ACC,Q}, go to FIN.
- FIN:
  - Lasts exactly one cycle; then go to IDLE.
  - If START=1 at FIN's edge, it is accepted as in IDLE (load, go to RUN); back-to-back operation is allowed.
- Outputs:
  - BUSY = 1 in RUN. The FIN and IDLE cycles have BUSY=0.
  - DONE = 1 only in FIN.
  - PRODUCT is registered. It changes only on entry to FIN or on reset, and is stable across IDLE and the next RUN.
- Latency:
  - The START-sampling edge is edge 1. DONE is high for the cycle after edge WIDTH+1 (edge 9 for WIDTH=8).
  - Throughput: one product per WIDTH+1 cycles with back-to-back START.
- START while BUSY=1 is ignored, with no queuing. A/B changes during RUN have no effect.
- Arithmetic is unsigned. Adder carry-out is always captured, so the maximum product (2^WIDTH-1)^2 is exact.
- ADD_CIN is always 0. The adder inputs are purely combinational from registers; no combinational path from ADD_SUM to any output.
- Multiplier 0 or multiplicand 0: the run still takes the full WIDTH iterations; PRODUCT=0.

Test Plan:
- Reset, then A=13, B=11, START for 1 cycle -> BUSY high 8 cycles; DONE pulses once at edge 9; PRODUCT=0x008F, held afterwards.
- A=255, B=255 -> PRODUCT=0xFE01; ADD_COUT=1 is observed and captured during the run.
- A=0, B=200, then A=200, B=0 -> both give PRODUCT=0x0000 after the full 9-cycle latency; DONE pulses each time.
- Start A=7, B=6; pulse START with A=3, B=3 at cycle 4; hold START high during FIN -> the mid-run START is ignored, first PRODUCT=0x002A. The START during FIN is accepted with the current A/B = 3/3, giving a second PRODUCT=0x0009 with no idle gap.
- A=100, B=100; assert RESET_N=0 at cycle 5 mid-run -> BUSY, DONE, PRODUCT and ADD_A drop to 0 asynchronously; no DONE appears after release. A new START then yields 0x2710.
- A=1, B=200 -> PRODUCT=0x00C8. Check ADD_B=0 on every iteration where Q[0]=0 and ADD_CIN=0 throughout.
